rotate_angle_gen: RTL
=====================

ROTATE_ANGLE_GEN -- requirements
Module: rotate_angle_gen

Interface
REQ-001 SHALL have parameters: ANGLE_WIDTH, default 10, width of sin_theta/cos_theta; PHASE_WIDTH, default 12, angle word width (full circle = 2^PHASE_WIDTH); ITERS, default 12, CORDIC iterations.
REQ-002 SHALL have one clock and asynchronous, active-high reset; ports: clk input 1, pixel-rate clock; reset input 1, async active-high reset.
REQ-003 SHALL have: enable input 1, when low, updates are frozen.
REQ-004 SHALL have: dvi input 1, stream data valid (snooped only).
REQ-005 SHALL have: dtypei input `DTYPE_WIDTH, stream data type (snooped only).
REQ-006 SHALL have: angle_target input PHASE_WIDTH, unsigned phase, 0 = 0 deg, 2^(PHASE_WIDTH-2) = 90 deg.
REQ-007 SHALL have: slew_step input PHASE_WIDTH, maximum phase change per frame; 0 means jump directly to target.
REQ-008 SHALL have: sin_theta output ANGLE_WIDTH signed, 1.0 = 2^(ANGLE_WIDTH-2); feeds the downstream rotation stage.
REQ-009 SHALL have: cos_theta output ANGLE_WIDTH signed, same scale.
REQ-010 SHALL have: angle_cur output PHASE_WIDTH, phase currently applied on sin_theta/cos_theta.
REQ-011 SHALL have: busy output 1, high while computing; updated output 1, one-cycle pulse on commit.

Function
REQ-012 SHALL decode frame_end = dvi && dtypei==`DTYPE_FRAME_END and frame_start = dvi && dtypei==`DTYPE_FRAME_START.
REQ-013 SHALL use FSM states IDLE, SLEW, ROT, READY; leave IDLE only on frame_end with enable high.
REQ-014 SHALL, in SLEW (1 cycle), set d = (angle_target - angle_next_base) mod 2^PHASE_WIDTH interpreted signed (shortest path); if slew_step==0 or |d|<=slew_step the new phase = angle_target, else base +/- slew_step, modulo wrap.
REQ-015 SHALL define angle_next_base as the last computed phase (shadow), not the committed one.
REQ-016 SHALL, in ROT, quadrant-fold the phase into +/-90 deg and run exactly ITERS iterative CORDIC cycles with ANGLE_WIDTH+4 internal bits, starting x = K*2^(ANGLE_WIDTH-2) (gain pre-compensated), y = 0.
REQ-017 SHALL round results to ANGLE_WIDTH and saturate to +/-2^(ANGLE_WIDTH-2); accuracy +/-2 LSB.
REQ-018 SHALL enter READY holding shadow sin/cos/phase, busy low; commit shadows to outputs on the first frame_start seen in READY, pulse updated, return to IDLE.
REQ-019 SHALL NOT commit on a frame_start arriving in SLEW or ROT; commit waits for a later frame_start (outputs constant for a whole frame).
REQ-020 SHALL ignore frame_end while not in IDLE; a frame_end in READY restarts SLEW from the shadow phase (newest target wins, no commit lost beyond one frame).
REQ-021 SHALL, when enable low, force FSM to IDLE, hold all outputs, and discard uncommitted shadows.
REQ-022 SHALL have latency frame_end -> READY = 1 + ITERS + 1 cycles.

Reset
REQ-023 SHALL on reset: sin_theta 0, cos_theta 2^(ANGLE_WIDTH-2), angle_cur 0, shadows equal, busy 0, updated 0, FSM IDLE; reset mid-ROT abandons computation.

Structure
REQ-024 SHALL take `DTYPE_* constants from the shared stream-type header; the arctangent table and CORDIC gain constant SHALL live in a shared package.
REQ-025 SHALL instantiate one sub-module cordic_sincos (iterative, start/done handshake); FSM and slew logic in the top.

Verification
REQ-026 Reset -> sin_theta 0, cos_theta 256, angle_cur 0, busy 0.
REQ-027 angle_target 1024, slew 0, frame_end then frame_start after 20 cycles -> sin 256+/-2, cos 0+/-2, angle_cur 1024, updated pulse once.
REQ-028 angle_target 512 -> sin 181+/-2, cos 181+/-2; angle_target 2048 -> sin 0+/-2, cos -256+/-2.
REQ-029 angle_cur 4000, target 100, slew 50, four frames -> angle_cur 4050, 4, 54, 100 (wrap through 0).
REQ-030 frame_start 3 cycles after frame_end -> outputs unchanged that frame; commit on next frame_start.
REQ-031 reset asserted mid-ROT -> outputs return to reset values, next frame_end computes normally.

Source files
------------

// File: rtl/rotate_angle_gen_pkg.sv
// rotate_angle_gen_pkg
//   Shared definitions for the rotate_angle_gen slice:
//   - stream data-type codes (DTYPE_*) snooped from the pixel stream
//   - FSM state type of the angle generator
//   - CORDIC arctangent table (in 2^-16 turn units) and gain constant
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_IDLE        4'd0
`define DTYPE_FRAME_START 4'd1
`define DTYPE_FRAME_END   4'd2
`define DTYPE_LINE_START  4'd3
`define DTYPE_PIXEL       4'd4
`endif

package rotate_angle_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SLEW,
        ROT,
        READY
    } state_t;

    // Angles inside the CORDIC are held as fractions of a full turn with
    // this many bits (PHASE_WIDTH must not exceed it).
    localparam int TURN_BITS = 16;

    // CORDIC gain 1/prod(sqrt(1+2^-2i)) in Q16.
    localparam int CORDIC_K_Q16 = 39797;

    // atan(2^-i) expressed in 2^-16 turn units.
    function automatic logic [TURN_BITS-1:0] cordic_atan(input int unsigned i);
        case (i)
            0:       return 16'd8192;
            1:       return 16'd4836;
            2:       return 16'd2555;
            3:       return 16'd1297;
            4:       return 16'd651;
            5:       return 16'd326;
            6:       return 16'd163;
            7:       return 16'd81;
            8:       return 16'd41;
            9:       return 16'd20;
            10:      return 16'd10;
            11:      return 16'd5;
            12:      return 16'd3;
            13:      return 16'd1;
            14:      return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    // Gain-compensated start value K * 2^(aw-2) with 4 extra fraction bits.
    function automatic int cordic_x0(input int aw);
        longint v;
        v = (longint'(CORDIC_K_Q16) << (aw + 2)) + 64'sd32768;
        return int'(v >>> 16);
    endfunction

endpackage

// File: rtl/rotate_angle_gen_if.sv
// rotate_angle_gen_if
//   Control, stream-snoop and result signals of rotate_angle_gen.
//   master: upstream controller / stream source (drives enable, dvi,
//           dtypei, angle_target, slew_step; reads results)
//   slave : rotate_angle_gen (reads controls, drives sin_theta, cos_theta,
//           angle_cur, busy, updated)
interface rotate_angle_gen_if #(
    parameter int ANGLE_WIDTH = 10,
    parameter int PHASE_WIDTH = 12
);
    logic                          enable;
    logic                          dvi;
    logic [`DTYPE_WIDTH-1:0]       dtypei;
    logic [PHASE_WIDTH-1:0]        angle_target;
    logic [PHASE_WIDTH-1:0]        slew_step;
    logic signed [ANGLE_WIDTH-1:0] sin_theta;
    logic signed [ANGLE_WIDTH-1:0] cos_theta;
    logic [PHASE_WIDTH-1:0]        angle_cur;
    logic                          busy;
    logic                          updated;

    modport master (
        output enable, dvi, dtypei, angle_target, slew_step,
        input  sin_theta, cos_theta, angle_cur, busy, updated
    );

    modport slave (
        input  enable, dvi, dtypei, angle_target, slew_step,
        output sin_theta, cos_theta, angle_cur, busy, updated
    );
endinterface

// File: rtl/rotate_angle_gen_cordic_sincos.sv
// cordic_sincos
//   Iterative rotation-mode CORDIC producing sin/cos of a phase word.
//   Ports:
//     clk, reset         clock, async active-high reset
//     start              load phase and begin (one cycle)
//     phase              unsigned phase, full turn = 2^PHASE_WIDTH
//     done               one-cycle pulse, sin_out/cos_out valid from then
//     sin_out, cos_out   signed results, 1.0 = 2^(ANGLE_WIDTH-2)
module cordic_sincos
    import rotate_angle_gen_pkg::*;
#(
    parameter int ANGLE_WIDTH = 10,
    parameter int PHASE_WIDTH = 12,
    parameter int ITERS       = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [PHASE_WIDTH-1:0]        phase,
    output logic                          done,
    output logic signed [ANGLE_WIDTH-1:0] sin_out,
    output logic signed [ANGLE_WIDTH-1:0] cos_out
);
    localparam int W  = ANGLE_WIDTH + 4;
    localparam int ZW = TURN_BITS + 2;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    localparam logic signed [W-1:0] X0   = W'(cordic_x0(ANGLE_WIDTH));
    localparam logic signed [W-1:0] ONE  = W'(1 << (ANGLE_WIDTH - 2));
    localparam logic signed [W-1:0] HALF = W'(8);

    logic signed [W-1:0]  x, y, xs, ys;
    logic signed [ZW-1:0] z, at;
    logic [CW-1:0]        iter;
    logic                 running;
    logic                 neg;

    logic [TURN_BITS-1:0] p16, z0_u;
    logic                 fold;

    // Phases outside [-90,+90) deg are moved by half a turn; the results
    // are negated afterwards (sin/cos(a-pi) = -sin/cos(a)).
    always_comb begin
        p16  = TURN_BITS'(phase) << (TURN_BITS - PHASE_WIDTH);
        fold = p16[TURN_BITS-1] ^ p16[TURN_BITS-2];
        z0_u = fold ? {~p16[TURN_BITS-1], p16[TURN_BITS-2:0]} : p16;
    end

    always_comb begin
        xs = x >>> iter;
        ys = y >>> iter;
        at = ZW'(cordic_atan(32'(iter)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            iter    <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                x       <= X0;
                y       <= '0;
                z       <= ZW'($signed(z0_u));
                neg     <= fold;
                iter    <= '0;
                running <= 1'b1;
            end else if (running) begin
                if (!z[ZW-1]) begin
                    x <= x - ys;
                    y <= y + xs;
                    z <= z - at;
                end else begin
                    x <= x + ys;
                    y <= y - xs;
                    z <= z + at;
                end
                if (32'(iter) == ITERS - 1) begin
                    iter    <= '0;
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    iter <= iter + CW'(1);
                end
            end
        end
    end

    function automatic logic signed [ANGLE_WIDTH-1:0] sat_round(
        input logic signed [W-1:0] v,
        input logic                n
    );
        logic signed [W-1:0] r;
        r = (v + HALF) >>> 4;
        if (r > ONE)
            r = ONE;
        else if (r < -ONE)
            r = -ONE;
        if (n)
            r = -r;
        return r[ANGLE_WIDTH-1:0];
    endfunction

    assign sin_out = sat_round(y, neg);
    assign cos_out = sat_round(x, neg);

endmodule

// File: rtl/rotate_angle_gen.sv
// rotate_angle_gen
//   Per-frame rotation angle generator. On each frame end it slews a shadow
//   phase toward angle_target, computes sin/cos with an iterative CORDIC and
//   commits the result to the outputs on the following frame start, so the
//   downstream rotation sees constant coefficients for a whole frame.
//   Ports:
//     clk    pixel-rate clock
//     reset  async active-high reset
//     bus    rotate_angle_gen_if.slave: enable, dvi, dtypei, angle_target,
//            slew_step in; sin_theta, cos_theta, angle_cur, busy, updated out
module rotate_angle_gen
    import rotate_angle_gen_pkg::*;
#(
    parameter int ANGLE_WIDTH = 10,
    parameter int PHASE_WIDTH = 12,
    parameter int ITERS       = 12
) (
    input  logic               clk,
    input  logic               reset,
    rotate_angle_gen_if.slave  bus
);
    localparam logic signed [ANGLE_WIDTH-1:0] ONE = ANGLE_WIDTH'(1 << (ANGLE_WIDTH - 2));

    state_t                        state;
    logic signed [ANGLE_WIDTH-1:0] sin_r, cos_r, shadow_sin, shadow_cos;
    logic [PHASE_WIDTH-1:0]        angle_r, shadow_phase;
    logic                          busy_r, updated_r;

    logic                          frame_end, frame_start;
    logic [PHASE_WIDTH-1:0]        diff, slew_phase;
    logic [PHASE_WIDTH:0]          mag;

    logic                          cordic_start, cordic_done;
    logic signed [ANGLE_WIDTH-1:0] cordic_sin, cordic_cos;

    assign frame_end   = bus.dvi && (bus.dtypei == `DTYPE_FRAME_END);
    assign frame_start = bus.dvi && (bus.dtypei == `DTYPE_FRAME_START);

    // Shortest-path slew from the shadow phase; diff read as signed.
    always_comb begin
        diff = bus.angle_target - shadow_phase;
        mag  = diff[PHASE_WIDTH-1] ? ({1'b0, ~diff} + (PHASE_WIDTH+1)'(1)) : {1'b0, diff};
        if (bus.slew_step == '0 || mag <= {1'b0, bus.slew_step})
            slew_phase = bus.angle_target;
        else if (diff[PHASE_WIDTH-1])
            slew_phase = shadow_phase - bus.slew_step;
        else
            slew_phase = shadow_phase + bus.slew_step;
    end

    // CORDIC loads in the SLEW cycle, straight from the slew result.
    assign cordic_start = (state == SLEW);

    cordic_sincos #(
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .PHASE_WIDTH (PHASE_WIDTH),
        .ITERS       (ITERS)
    ) u_cordic (
        .clk     (clk),
        .reset   (reset),
        .start   (cordic_start),
        .phase   (slew_phase),
        .done    (cordic_done),
        .sin_out (cordic_sin),
        .cos_out (cordic_cos)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sin_r        <= '0;
            cos_r        <= ONE;
            angle_r      <= '0;
            shadow_sin   <= '0;
            shadow_cos   <= ONE;
            shadow_phase <= '0;
            busy_r       <= 1'b0;
            updated_r    <= 1'b0;
        end else begin
            updated_r <= 1'b0;
            if (!bus.enable) begin
                state        <= IDLE;
                busy_r       <= 1'b0;
                shadow_phase <= angle_r;
                shadow_sin   <= sin_r;
                shadow_cos   <= cos_r;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_end) begin
                            state  <= SLEW;
                            busy_r <= 1'b1;
                        end
                    end
                    SLEW: begin
                        shadow_phase <= slew_phase;
                        state        <= ROT;
                    end
                    ROT: begin
                        if (cordic_done) begin
                            shadow_sin <= cordic_sin;
                            shadow_cos <= cordic_cos;
                            state      <= READY;
                            busy_r     <= 1'b0;
                        end
                    end
                    READY: begin
                        if (frame_start) begin
                            sin_r     <= shadow_sin;
                            cos_r     <= shadow_cos;
                            angle_r   <= shadow_phase;
                            updated_r <= 1'b1;
                            state     <= IDLE;
                        end else if (frame_end) begin
                            state  <= SLEW;
                            busy_r <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sin_theta = sin_r;
    assign bus.cos_theta = cos_r;
    assign bus.angle_cur = angle_r;
    assign bus.busy      = busy_r;
    assign bus.updated   = updated_r;

endmodule
